booth_mul4: RTL and testbench

Sequential 4×4 signed multiplier controller built around one shared instance of the team's 4-bit `addsub` unit.
- Radix-2 Booth: one add, subtract or skip per cycle, then an arithmetic shift, over 4 iterations.
- Produces an 8-bit two's-complement product with a start/busy/done handshake.
- Sits beside the add/sub datapath as its first sequencing client; it drives the unit's `M` input from the FSM.

---
 rtl/booth_mul4.sv | 157 +++++++++++++++
 tb/tb_booth_mul4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul4.sv
// booth_mul4 -- sequential 4x4 signed radix-2 Booth multiplier.
// One add/subtract/skip plus arithmetic shift per cycle, four iterations,
// built around a single shared 4-bit addsub unit.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request, sampled only in IDLE
//   A      in   4  multiplicand, signed
//   B      in   4  multiplier, signed
//   P      out  8  product register, signed; holds until next completion
//   busy   out  1  high while in CALC or DONE
//   done   out  1  one-cycle pulse when P is newly valid

// addsub -- 4-bit adder/subtractor: s = a + b (m=0) or a - b (m=1).
// Ports: a_i, b_i (4) operands; m_i mode; s_o (4) result; co_o carry out;
// v_o signed overflow.
module addsub (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       m_i,
    output logic [3:0] s_o,
    output logic       co_o,
    output logic       v_o
);
    logic [3:0] b_eff;
    logic [4:0] sum;

    // Subtract as a + ~b + 1.
    always_comb begin
        b_eff = b_i ^ {4{m_i}};
        sum   = 5'(a_i) + 5'(b_eff) + 5'(m_i);
        s_o   = sum[3:0];
        co_o  = sum[4];
        v_o   = (a_i[3] == b_eff[3]) && (sum[3] != a_i[3]);
    end
endmodule

module booth_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);
    localparam int unsigned OpW   = 4;
    localparam int unsigned ProdW = 8;
    localparam int unsigned CntW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [OpW-1:0]     mc_q;
    logic [OpW-1:0]     ac_q;
    logic [OpW-1:0]     q_q;
    logic               q1_q;
    logic [CntW-1:0]    cnt_q;
    logic [ProdW-1:0]   p_q;
    logic               busy_q;
    logic               done_q;

    logic [1:0]         pair;
    logic               m_sel;
    logic               use_as;
    logic [OpW-1:0]     as_sum;
    logic               as_v;
    logic               co_unused;
    logic [OpW-1:0]     t_val;
    logic               sign_bit;
    logic [OpW-1:0]     ac_d;
    logic [OpW-1:0]     q_d;
    logic               q1_d;

    // Shared add/sub unit; mode comes from the Booth pair.
    addsub u_addsub (
        .a_i  (ac_q),
        .b_i  (mc_q),
        .m_i  (m_sel),
        .s_o  (as_sum),
        .co_o (co_unused),
        .v_o  (as_v)
    );

    // One Booth step: select T and its true sign, then arithmetic shift right.
    always_comb begin
        pair     = {q_q[0], q1_q};
        m_sel    = (pair == 2'b10);
        use_as   = pair[1] ^ pair[0];
        t_val    = use_as ? as_sum : ac_q;
        // S[3]^V recovers the 5-bit sign when the 4-bit add/sub overflows.
        sign_bit = use_as ? (as_sum[3] ^ as_v) : ac_q[3];
        ac_d     = {sign_bit, t_val[3:1]};
        q_d      = {t_val[0], q_q[3:1]};
        q1_d     = q_q[0];
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mc_q    <= '0;
            ac_q    <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mc_q    <= A;
                        q_q     <= B;
                        ac_q    <= '0;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    ac_q  <= ac_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= CntW'(cnt_q + 1'b1);
                    if (cnt_q == CntW'(3)) begin
                        p_q     <= {ac_d, q_d};
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_booth_mul4.sv
// tb_booth_mul4 -- self-checking bench for booth_mul4: directed spec cases,
// randomized runs with ignored mid-run requests, an exhaustive back-to-back
// sweep with start held high, and a reset abort.
module tb_booth_mul4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [7:0] p_out;
    logic       busy;
    logic       done;

    int n_checks;
    int n_errors;
    logic [7:0] prev_p;

    booth_mul4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .P     (p_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain signed integer multiply truncated to 8 bits.
    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int pa;
        int pb;
        pa = $signed(a);
        pb = $signed(b);
        return 8'(pa * pb);
    endfunction

    // One transaction: accept at E0, then sample after E0..E5.
    // hold keeps start high throughout; poke issues ignored requests mid-run.
    task automatic run_one(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_p, input bit hold, input bit poke);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("busy_e%0d", e), 8'(busy), 8'(e <= 4));
            check_eq($sformatf("done_e%0d", e), 8'(done), 8'(e == 4));
            check_eq($sformatf("p_e%0d", e), p_out, (e >= 4) ? exp_p : prev_p);
            if (!hold) begin
                if (e == 0) start = 1'b0;
                if (poke) begin
                    if (e == 1) begin
                        a_in  = 4'($urandom);
                        b_in  = 4'($urandom);
                        start = 1'b1;
                    end
                    if (e == 2) start = 1'b0;
                    if (e == 3) start = 1'b1;
                    if (e == 5) start = 1'b0;
                end
            end
        end
        prev_p = exp_p;
        if (poke && !hold) begin
            @(posedge clk);
            #1;
            check_eq("poke_idle_busy", 8'(busy), 8'h00);
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        int off;

        n_checks = 0;
        n_errors = 0;
        prev_p   = 8'h00;
        rst      = 1'b1;
        start    = 1'b0;
        a_in     = 4'h0;
        b_in     = 4'h0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_p", p_out, 8'h00);
            check_eq("rst_busy", 8'(busy), 8'h00);
            check_eq("rst_done", 8'(done), 8'h00);
        end

        // Directed cases with known products.
        run_one(4'd3, 4'd5, 8'h0F, 1'b0, 1'b0);
        run_one(4'h8, 4'h8, 8'h40, 1'b0, 1'b0);
        run_one(4'h8, 4'h7, 8'hC8, 1'b0, 1'b0);
        run_one(4'h7, 4'hF, 8'hF9, 1'b0, 1'b0);
        run_one(4'h0, 4'hB, 8'h00, 1'b0, 1'b0);
        run_one(4'h7, 4'hF, 8'hF9, 1'b0, 1'b1);

        // Randomized runs with idle gaps and ignored requests.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_one(ra, rb, ref_prod(ra, rb), 1'b0, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Exhaustive sweep, back-to-back with start held high, random start offset.
        off = int'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) begin
            ra = 4'((k + off) % 256);
            rb = 4'(((k + off) % 256) >> 4);
            run_one(ra, rb, ref_prod(ra, rb), 1'b1, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("sweep_end_busy", 8'(busy), 8'h00);

        // Reset abort at E2.
        @(negedge clk);
        a_in  = 4'd6;
        b_in  = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_p", p_out, 8'h00);
        check_eq("abort_busy", 8'(busy), 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_done", 8'(done), 8'h00);
            check_eq("abort_p_hold", p_out, 8'h00);
        end
        @(negedge clk);
        rst    = 1'b0;
        prev_p = 8'h00;
        run_one(4'd3, 4'd5, 8'h0F, 1'b0, 1'b0);
        ra = 4'($urandom);
        rb = 4'($urandom);
        run_one(ra, rb, ref_prod(ra, rb), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
